// File: rtl/game_clock_multi.sv
// N-player game clock: turn FSM, per-player countdown timers, Fischer increment, elimination.
// Optional per-turn simple delay enabled by defining GAME_CLOCK_DELAY_EN.
module game_clock_multi #(
    parameter int unsigned N_PLAYERS = 4,
    parameter int unsigned TIME_W    = 16,
    parameter int unsigned INIT_TIME = 300,
    parameter int unsigned INC_TIME  = 0
`ifdef GAME_CLOCK_DELAY_EN
    ,
    parameter int unsigned DELAY_TICKS = 3
`endif
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_restart,
    input  logic                          i_stop,
    input  logic [N_PLAYERS-1:0]          i_press,
    input  logic                          i_tick,
    output logic [N_PLAYERS*TIME_W-1:0]   o_time,
    output logic [N_PLAYERS-1:0]          o_active,
    output logic [N_PLAYERS-1:0]          o_out,
    output logic [N_PLAYERS-1:0]          o_winner,
    output logic                          o_idle,
    output logic                          o_paused
);

    localparam int unsigned CUR_W = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1;
    localparam int unsigned SUM_W = TIME_W + 1;

    typedef enum logic [2:0] {StStart, StIdle, StRun, StPause, StDone} state_e;

    state_e                 state_q, state_d;
    logic [TIME_W-1:0]      timer_q [N_PLAYERS];
    logic [TIME_W-1:0]      timer_d [N_PLAYERS];
    logic [N_PLAYERS-1:0]   out_q, out_d;
    logic [CUR_W-1:0]       cur_q, cur_d, idle_pick;
    logic [N_PLAYERS-1:0]   cur_oh, flag_mask;
    logic [SUM_W-1:0]       sum;
    logic [TIME_W-1:0]      sat_time;
    logic                   tick_eff, load_delay, tick_run;

    // First non-eliminated player after c, scanning cyclically.
    function automatic logic [CUR_W-1:0] next_player(input logic [CUR_W-1:0] c,
                                                     input logic [N_PLAYERS-1:0] m);
        logic found;
        int   idx;
        next_player = c;
        found = 1'b0;
        for (int i = 1; i < int'(N_PLAYERS); i++) begin
            idx = (int'(c) + i) % int'(N_PLAYERS);
            if (!found && !m[idx]) begin
                next_player = CUR_W'(idx);
                found = 1'b1;
            end
        end
    endfunction

`ifdef GAME_CLOCK_DELAY_EN
    logic [TIME_W-1:0] delay_q, delay_d;

    assign tick_eff = i_tick && (delay_q == '0);

    always_comb begin
        delay_d = delay_q;
        if (load_delay) begin
            delay_d = TIME_W'(DELAY_TICKS);
        end else if (tick_run && delay_q != '0) begin
            delay_d = delay_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            delay_q <= '0;
        end else begin
            delay_q <= delay_d;
        end
    end
`else
    logic unused_delay_ctl;
    assign tick_eff = i_tick;
    assign unused_delay_ctl = load_delay ^ tick_run;
`endif

    always_comb begin
        cur_oh    = N_PLAYERS'(1) << cur_q;
        flag_mask = out_q | cur_oh;
        // Press-cycle update; flag has priority, so the timer is nonzero here.
        sum       = SUM_W'(timer_q[cur_q]) - SUM_W'(tick_eff) + SUM_W'(INC_TIME);
        sat_time  = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
        idle_pick = '0;
        for (int p = int'(N_PLAYERS) - 1; p >= 0; p--) begin
            if (i_press[p]) idle_pick = CUR_W'(p);
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        out_d      = out_q;
        cur_d      = cur_q;
        load_delay = 1'b0;
        tick_run   = 1'b0;
        case (state_q)
            StStart: begin
                for (int p = 0; p < int'(N_PLAYERS); p++) timer_d[p] = TIME_W'(INIT_TIME);
                out_d   = '0;
                cur_d   = '0;
                state_d = StIdle;
            end
            StIdle: begin
                if (|i_press) begin
                    cur_d      = idle_pick;
                    state_d    = StRun;
                    load_delay = 1'b1;
                end
            end
            StRun: begin
                if (i_restart) begin
                    state_d = StStart;
                end else if (i_stop) begin
                    state_d = StPause;
                end else if (timer_q[cur_q] == '0) begin
                    out_d      = flag_mask;
                    cur_d      = next_player(cur_q, flag_mask);
                    load_delay = 1'b1;
                    if ($countones(~flag_mask) == 1) state_d = StDone;
                end else if (i_press[cur_q]) begin
                    timer_d[cur_q] = sat_time;
                    cur_d          = next_player(cur_q, out_q);
                    load_delay     = 1'b1;
                end else if (i_tick) begin
                    tick_run = 1'b1;
                    if (tick_eff) timer_d[cur_q] = timer_q[cur_q] - 1'b1;
                end
            end
            StPause: begin
                if (i_restart) begin
                    state_d = StStart;
                end else if (i_press[cur_q]) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (i_restart) state_d = StStart;
            end
            default: state_d = StStart;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StStart;
            for (int p = 0; p < int'(N_PLAYERS); p++) timer_q[p] <= TIME_W'(INIT_TIME);
            out_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        o_time = '0;
        for (int p = 0; p < int'(N_PLAYERS); p++) o_time[p*TIME_W +: TIME_W] = timer_q[p];
        o_active = (state_q == StRun) ? cur_oh : '0;
        o_winner = (state_q == StDone) ? cur_oh : '0;
        o_out    = out_q;
        o_idle   = (state_q == StIdle);
        o_paused = (state_q == StPause);
    end

endmodule
